// File: rtl/one_hot_pkg.sv
// Shared types and helpers for the one-hot to binary decoder.
//   oh_class_e   : classification of a one-hot candidate vector
//   oh_class()   : classifies a vector from its popcount
//   bin_width_ok : legality check for the ONE_HOT/BINARY parameter pair
package one_hot_pkg;

  typedef enum logic [1:0] {
    OH_LEGAL = 2'd0,
    OH_ZERO  = 2'd1,
    OH_MULTI = 2'd2
  } oh_class_e;

  localparam int unsigned OneHotDefault = 16;
  localparam int unsigned BinaryDefault = 4;

  function automatic bit bin_width_ok(input int unsigned one_hot, input int unsigned binary);
    return (one_hot >= 2) && (binary == $clog2(one_hot));
  endfunction

  localparam bit DefaultWidthOk = bin_width_ok(OneHotDefault, BinaryDefault);

  // 0 bits set -> zero-hot, 1 bit -> legal, anything above -> multi-hot.
  function automatic oh_class_e oh_class(input int unsigned ones);
    if (ones == 0) begin
      return OH_ZERO;
    end else if (ones == 1) begin
      return OH_LEGAL;
    end else begin
      return OH_MULTI;
    end
  endfunction

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit priority encoder.
//   vec_i : input vector
//   idx_o : index of the lowest set bit (0 when none set)
//   any_o : at least one bit of vec_i is set
module lsb_priority_encoder #(
  parameter int unsigned ONE_HOT = 16,
  parameter int unsigned BINARY  = 4
) (
  input  logic [ONE_HOT-1:0] vec_i,
  output logic [BINARY-1:0]  idx_o,
  output logic               any_o
);

  // Scan from the top down so the last hit, the lowest set bit, wins.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int i = int'(ONE_HOT) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = BINARY'(i);
      end
    end
  end

endmodule

// File: rtl/one_hot_binary_decoder.sv
// Two-stage pipelined one-hot to binary decoder with valid/ready on both sides.
// S1 captures the raw vector, S2 holds the encoded index and zero/multi-hot flags.
//   Clk_I, Rst_I        : clock, synchronous active-high reset
//   Valid_I/Ready_O     : input handshake, One_Hot_I is the beat
//   Valid_O/Ready_I     : output handshake, Bin_O/Zero_Hot_O/Multi_Hot_O is the beat
//   Clr_Count_I         : synchronous clear of the error counter
//   Err_Count_O         : saturating count of delivered illegal beats
module one_hot_binary_decoder
  import one_hot_pkg::*;
#(
  parameter int unsigned ONE_HOT = 16,
  parameter int unsigned BINARY  = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               Clk_I,
  input  logic               Rst_I,
  input  logic               Valid_I,
  output logic               Ready_O,
  input  logic [ONE_HOT-1:0] One_Hot_I,
  output logic               Valid_O,
  input  logic               Ready_I,
  output logic [BINARY-1:0]  Bin_O,
  output logic               Zero_Hot_O,
  output logic               Multi_Hot_O,
  input  logic               Clr_Count_I,
  output logic [CNT_W-1:0]   Err_Count_O
);

  localparam bit WidthOk = bin_width_ok(ONE_HOT, BINARY);

  if (!WidthOk) begin : g_bad_width
    $error("one_hot_binary_decoder: BINARY must equal $clog2(ONE_HOT) with ONE_HOT >= 2");
  end

  logic               v1_q, v1_d, v2_q, v2_d;
  logic [ONE_HOT-1:0] s1_q, s1_d;
  logic [BINARY-1:0]  bin_q, bin_d;
  logic               zero_q, zero_d, multi_q, multi_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               s2_ready, in_acc, s1_adv, out_xfer;
  logic [BINARY-1:0]  lsb_idx;
  logic               any_set;
  int unsigned        ones;
  oh_class_e          cls;

  lsb_priority_encoder #(
    .ONE_HOT (ONE_HOT),
    .BINARY  (BINARY)
  ) u_enc (
    .vec_i (s1_q),
    .idx_o (lsb_idx),
    .any_o (any_set)
  );

  always_comb begin
    ones = 32'($countones(s1_q));
    cls  = oh_class(ones);

    s2_ready = !v2_q || Ready_I;
    // Gated by reset so upstream never sees a handshake while the pipe is being flushed.
    Ready_O  = !Rst_I && (!v1_q || s2_ready);
    Valid_O  = !Rst_I && v2_q;
    in_acc   = Valid_I && Ready_O;
    s1_adv   = v1_q && s2_ready;
    out_xfer = Valid_O && Ready_I;

    v1_d = v1_q;
    s1_d = s1_q;
    if (!v1_q || s2_ready) begin
      v1_d = in_acc;
    end
    if (in_acc) begin
      s1_d = One_Hot_I;
    end

    v2_d    = v2_q;
    bin_d   = bin_q;
    zero_d  = zero_q;
    multi_d = multi_q;
    if (s2_ready) begin
      v2_d = v1_q;
    end
    if (s1_adv) begin
      bin_d   = any_set ? lsb_idx : '0;
      zero_d  = (cls == OH_ZERO);
      multi_d = (cls == OH_MULTI);
    end

    // Clear has priority over an increment in the same cycle.
    cnt_d = cnt_q;
    if (Clr_Count_I) begin
      cnt_d = '0;
    end else if (out_xfer && (zero_q || multi_q) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk_I) begin
    if (Rst_I) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      s1_q    <= '0;
      bin_q   <= '0;
      zero_q  <= 1'b0;
      multi_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      s1_q    <= s1_d;
      bin_q   <= bin_d;
      zero_q  <= zero_d;
      multi_q <= multi_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Bin_O       = bin_q;
  assign Zero_Hot_O  = zero_q;
  assign Multi_Hot_O = multi_q;
  assign Err_Count_O = cnt_q;

endmodule

// File: doc/one_hot_binary_decoder.md
# one_hot_binary_decoder

Pipelined decoder converting a one-hot vector back to its binary index, the receive-side counterpart of the team's binary-to-one-hot encoder. Each vector is classified as legal one-hot, zero-hot, or multi-hot, and non-legal vectors are flagged. A saturating error counter tracks them. Sits between a one-hot select/grant source and binary-indexed consumers, with valid/ready flow control on both sides.

## Interface
- ONE_HOT, default 16: width of the one-hot input; must be ≥ 2.
- BINARY, default 4: width of the binary output; must equal $clog2(ONE_HOT).
- CNT_W, default 8: width of the error counter.

- Clk_I  input  1  clock; all state updates on its rising edge.
- Rst_I  input  1  reset; synchronous, active-high.
- Valid_I  input  1  One_Hot_I carries a beat.
- Ready_O  output  1  block accepts a beat this cycle.
- One_Hot_I  input  ONE_HOT  vector to decode.
- Valid_O  output  1  output beat present.
- Ready_I  input  1  downstream accepts the output beat.
- Bin_O  output  BINARY  decoded index.
- Zero_Hot_O  output  1  beat's input had no bit set.
- Multi_Hot_O  output  1  beat's input had more than one bit set.
- Clr_Count_I  input  1  synchronous clear of Err_Count_O.
- Err_Count_O  output  CNT_W  count of illegal beats delivered, saturating.

## Operation
- Two register stages, S1 and S2, each with its own valid bit (v1, v2).
- S1 captures One_Hot_I.
- S2 holds the encoded result and flags. Encoding is combinational on S1 data, registered into S2.
- Stage advance rules:
  - s2_ready = !v2 || Ready_I
  - Ready_O = !v1 || s2_ready
  - Input accept when Valid_I && Ready_O; output transfer when Valid_O && Ready_I. Valid_O = v2.
- Classification of the S1 vector:
  - Exactly one bit set: Bin_O = index of that bit, both flags 0.
  - No bit set: Bin_O = 0, Zero_Hot_O = 1, Multi_Hot_O = 0.
  - Two or more bits set: Bin_O = index of the lowest set bit, Multi_Hot_O = 1, Zero_Hot_O = 0.
- Zero_Hot_O and Multi_Hot_O are never both 1.
- Error counter:
  - Increments by 1 on each output transfer where Zero_Hot_O or Multi_Hot_O is 1.
  - Holds at 2^CNT_W−1; never wraps.
  - Clr_Count_I sets it to 0. If a clear and an increment occur in the same cycle, the clear wins and the result is 0.
- Reset clears v1, v2, Bin_O, both flags, Err_Count_O and S1 data to 0.
- Reset mid-operation discards all in-flight beats; they are never delivered.

## Timing
- Latency: a beat accepted at edge N appears on Valid_O/Bin_O after edge N+2 when no stall occurs.
- Throughput: one beat per cycle while Ready_I stays high.
- Backpressure:
  - While Valid_O && !Ready_I, Bin_O, Zero_Hot_O and Multi_Hot_O hold stable.
  - The pipeline holds at most 2 beats; Ready_O falls only when both stages are full and Ready_I = 0.
  - Ready_O depends combinationally on Ready_I. No combinational path runs from Valid_I to any output.
- Simultaneous transfer out of S2 and advance of S1 into S2 in one cycle is allowed and loses no beat.
- While Rst_I = 1: Ready_O = 0 and Valid_O = 0. On the first cycle after reset releases, Ready_O = 1.
- Err_Count_O updates on the edge of the transfer. It is visible in the following cycle.

## Structure
- Package one_hot_pkg holds:
  - enum oh_class_e {OH_LEGAL, OH_ZERO, OH_MULTI}.
  - Function oh_class(), which classifies a vector by its popcount range.
  - The localparam check BINARY == $clog2(ONE_HOT).
- One sub-module, lsb_priority_encoder (parameters ONE_HOT, BINARY). It is combinational and outputs the lowest-set-bit index plus an any-set flag. The multi-hot check stays in the top level.

## Test plan
- Sweep 16'h0001 to 16'h8000 with Ready_I = 1 → Bin_O = 0..15, flags 0, one beat per cycle, each beat 2 cycles after its accept, Err_Count_O = 0.
- Send 16'h0000 → Bin_O = 0, Zero_Hot_O = 1. Send 16'h0120 → Bin_O = 5, Multi_Hot_O = 1. Err_Count_O = 2 afterwards.
- Hold Ready_I = 0 and offer 3 beats (16'h0004, 16'h0010, 16'h0400) → Ready_O falls after 2 accepts and Bin_O holds at 2. Raise Ready_I → outputs 2, 4, 10 in order, none lost or duplicated.
- CNT_W = 2 with 5 illegal beats → Err_Count_O stops at 3. Clr_Count_I in the same cycle as an illegal transfer → Err_Count_O = 0.
- Assert Rst_I while both stages are full → Valid_O = 0 on the next cycle. The discarded beats never appear, and all outputs are 0.
- Random Valid_I/Ready_I toggling against a scoreboard (50k beats, mixed legal/illegal) → in-order match, and the flags are never both high.
